// File: rtl/mpu_load_feeder_pkg.sv
// Shared definitions for the matrix load feeder.
// global_defs carries the matrix-unit geometry and element format used
// across the MPU; mpu_pkg carries the feeder's own state encoding and
// counter widths derived from that geometry.

package global_defs;
  localparam int M               = 4;
  localparam int N               = 4;
  localparam int MBITS           = 2;
  localparam int NBITS           = 2;
  localparam int FPBITS          = 31;
  localparam int MATRIX_REG_BITS = 2;
endpackage

package mpu_pkg;
  import global_defs::*;

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_FILL,
    FEED_DRAIN,
    FEED_GAP
  } feed_state_t;

  // Wide enough to hold a full-matrix element count (0..M*N).
  localparam int ELEM_CNT_BITS = $clog2(M * N + 1);

  // Largest legal row/column counts, sized to the command fields.
  localparam logic [MBITS:0] M_MAX = (MBITS + 1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS + 1)'(N);
endpackage

// File: rtl/mpu_load_feeder_if.sv
// Bundle of the feeder's command, source-stream and load-unit signals.
// slave is the feeder's view; master is the view of whatever drives the
// feeder (memory front end and load unit together).

interface mpu_load_feeder_if;
  import global_defs::*;

  logic                     cmd_valid_in;
  logic                     cmd_ready_out;
  logic [MATRIX_REG_BITS:0] cmd_addr_in;
  logic [MBITS:0]           cmd_m_size_in;
  logic [NBITS:0]           cmd_n_size_in;

  logic                     src_valid_in;
  logic                     src_ready_out;
  logic [FPBITS:0]          src_element_in;

  logic                     load_en_out;
  logic [FPBITS:0]          mem_load_element_out;
  logic [MATRIX_REG_BITS:0] mem_load_addr_out;
  logic [MBITS:0]           mem_m_load_size_out;
  logic [NBITS:0]           mem_n_load_size_out;
  logic                     mem_load_ack_in;
  logic                     mem_load_error_in;

  logic                     busy_out;
  logic                     done_out;
  logic                     error_out;

  modport slave (
    input  cmd_valid_in, cmd_addr_in, cmd_m_size_in, cmd_n_size_in,
    input  src_valid_in, src_element_in,
    input  mem_load_ack_in, mem_load_error_in,
    output cmd_ready_out, src_ready_out,
    output load_en_out, mem_load_element_out, mem_load_addr_out,
    output mem_m_load_size_out, mem_n_load_size_out,
    output busy_out, done_out, error_out
  );

  modport master (
    output cmd_valid_in, cmd_addr_in, cmd_m_size_in, cmd_n_size_in,
    output src_valid_in, src_element_in,
    output mem_load_ack_in, mem_load_error_in,
    input  cmd_ready_out, src_ready_out,
    input  load_en_out, mem_load_element_out, mem_load_addr_out,
    input  mem_m_load_size_out, mem_n_load_size_out,
    input  busy_out, done_out, error_out
  );
endinterface

// File: rtl/mpu_load_feeder_buffer.sv
// Element store for one matrix: a synchronous write port fed by the source
// stream and an asynchronous read port so the drain side can present
// buf[rd_cnt] in the same cycle the pointer changes. Contents are never
// reset; validity is tracked entirely by the feeder's counters.

module mpu_feed_buffer
  import global_defs::*;
#(
  parameter int DEPTH = M * N,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [FPBITS:0] wr_data_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic [FPBITS:0] rd_data_o
);

  logic [FPBITS:0] mem_q [DEPTH];

  // Capture one source element per accepted handshake.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mpu_load_feeder.sv
// Upstream stage of the matrix load unit. Accepts a load command, buffers
// the whole m x n matrix from a valid/ready source, then replays it to the
// load unit as one unbroken burst with load_en held high, followed by one
// idle gap cycle so the load unit can reset its row/column pointers.
// Optional build macro: MPU_FEED_TIMEOUT_EN adds a source-stall timeout in
// the fill phase (TIMEOUT_CYCLES idle cycles aborts the command).

module mpu_load_feeder
  import global_defs::*;
  import mpu_pkg::*;
#(
  parameter int BUF_DEPTH      = M * N,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  mpu_load_feeder_if.slave   bus
);

  localparam int BUF_AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  // Elaboration-time sanity checks on the configuration.
  if (BUF_DEPTH < M * N) begin : g_bad_depth
    $error("mpu_load_feeder: BUF_DEPTH must hold a full M*N matrix");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mpu_load_feeder: TIMEOUT_CYCLES must be at least 2");
  end

  feed_state_t              state_q, state_d;
  logic [ELEM_CNT_BITS-1:0] wr_cnt_q, wr_cnt_d;
  logic [ELEM_CNT_BITS-1:0] rd_cnt_q, rd_cnt_d;
  logic [ELEM_CNT_BITS-1:0] total_q, total_d;
  logic [MATRIX_REG_BITS:0] addr_q, addr_d;
  logic [MBITS:0]           m_q, m_d;
  logic [NBITS:0]           n_q, n_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;

`ifdef MPU_FEED_TIMEOUT_EN
  localparam int STALL_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_BITS-1:0] STALL_LAST = STALL_BITS'(TIMEOUT_CYCLES - 1);
  logic [STALL_BITS-1:0] stall_q, stall_d;
`endif

  logic [ELEM_CNT_BITS-1:0] lastIdx;
  logic                     srcFire;
  logic                     cmdBad;
  logic [FPBITS:0]          rdData;

  assign lastIdx = total_q - ELEM_CNT_BITS'(1);
  assign srcFire = (state_q == FEED_FILL) && bus.src_valid_in;
  assign cmdBad  = (bus.cmd_m_size_in == '0) || (bus.cmd_n_size_in == '0) ||
                   (bus.cmd_m_size_in > M_MAX) || (bus.cmd_n_size_in > N_MAX);

  mpu_feed_buffer #(
    .DEPTH (BUF_DEPTH),
    .AW    (BUF_AW)
  ) u_buffer (
    .clk       (clk),
    .wr_en_i   (srcFire),
    .wr_addr_i (BUF_AW'(wr_cnt_q)),
    .wr_data_i (bus.src_element_in),
    .rd_addr_i (BUF_AW'(rd_cnt_q)),
    .rd_data_o (rdData)
  );

  // State, pointers, command latches and pulse flags; reset drops any
  // partially buffered matrix immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FEED_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      total_q  <= '0;
      addr_q   <= '0;
      m_q      <= '0;
      n_q      <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef MPU_FEED_TIMEOUT_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      total_q  <= total_d;
      addr_q   <= addr_d;
      m_q      <= m_d;
      n_q      <= n_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef MPU_FEED_TIMEOUT_EN
      stall_q  <= stall_d;
`endif
    end
  end

  // Next-state logic: accept/validate, fill until the matrix is complete,
  // drain on load-unit acks, then one gap cycle before reporting done.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    total_d  = total_q;
    addr_d   = addr_q;
    m_d      = m_q;
    n_d      = n_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
`ifdef MPU_FEED_TIMEOUT_EN
    stall_d  = '0;
`endif

    case (state_q)
      FEED_IDLE: begin
        if (bus.cmd_valid_in) begin
          addr_d = bus.cmd_addr_in;
          m_d    = bus.cmd_m_size_in;
          n_d    = bus.cmd_n_size_in;
          if (cmdBad) begin
            error_d = 1'b1;
          end else begin
            state_d  = FEED_FILL;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            total_d  = ELEM_CNT_BITS'(bus.cmd_m_size_in) *
                       ELEM_CNT_BITS'(bus.cmd_n_size_in);
          end
        end
      end

      FEED_FILL: begin
        if (srcFire) begin
          if (wr_cnt_q == lastIdx) begin
            state_d  = FEED_DRAIN;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + ELEM_CNT_BITS'(1);
          end
        end
`ifdef MPU_FEED_TIMEOUT_EN
        else if (stall_q == STALL_LAST) begin
          state_d  = FEED_IDLE;
          wr_cnt_d = '0;
          error_d  = 1'b1;
        end else begin
          stall_d = stall_q + STALL_BITS'(1);
        end
`endif
      end

      FEED_DRAIN: begin
        if (bus.mem_load_error_in) begin
          state_d  = FEED_IDLE;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          error_d  = 1'b1;
        end else if (bus.mem_load_ack_in) begin
          if (rd_cnt_q == lastIdx) begin
            state_d  = FEED_GAP;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + ELEM_CNT_BITS'(1);
          end
        end
      end

      FEED_GAP: begin
        state_d = FEED_IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = FEED_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready_out        = (state_q == FEED_IDLE);
  assign bus.src_ready_out        = (state_q == FEED_FILL);
  assign bus.load_en_out          = (state_q == FEED_DRAIN);
  assign bus.busy_out             = (state_q != FEED_IDLE);
  assign bus.done_out             = done_q;
  assign bus.error_out            = error_q;
  assign bus.mem_load_element_out = (state_q == FEED_DRAIN) ? rdData : '0;
  assign bus.mem_load_addr_out    = addr_q;
  assign bus.mem_m_load_size_out  = m_q;
  assign bus.mem_n_load_size_out  = n_q;

endmodule

// File: tb/tb_mpu_load_feeder.sv
// Directed self-checking bench for mpu_load_feeder. Inputs change and
// outputs are sampled on the falling clock edge. The stall-timeout scenario
// is compiled only when MPU_FEED_TIMEOUT_EN is defined.

module tb_mpu_load_feeder;
  import global_defs::*;

  logic clk = 1'b0;
  logic rst_n;

  int totalChecks = 0;
  int badChecks   = 0;

  // IEEE-754 single values 1.0 .. 8.0
  logic [31:0] srcData [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  // Drain-stall scenario: ack per drain cycle and which element must show.
  logic ackSeq [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int   idxSeq [7] = '{0, 1, 1, 1, 1, 2, 3};

  always #5 clk = ~clk;

  mpu_load_feeder_if bus ();

  mpu_load_feeder #(
    .BUF_DEPTH      (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Present one load command for a single cycle.
  task automatic applyStimulus(input logic [2:0] addr, input logic [2:0] m,
                               input logic [2:0] n);
    bus.cmd_valid_in  = 1'b1;
    bus.cmd_addr_in   = addr;
    bus.cmd_m_size_in = m;
    bus.cmd_n_size_in = n;
    @(negedge clk);
    bus.cmd_valid_in  = 1'b0;
  endtask

  // Every output at its reset value.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(bus.cmd_ready_out), 32'd1);
    checkOutput({tag, "_src_ready"}, 32'(bus.src_ready_out), 32'd0);
    checkOutput({tag, "_load_en"},   32'(bus.load_en_out), 32'd0);
    checkOutput({tag, "_busy"},      32'(bus.busy_out), 32'd0);
    checkOutput({tag, "_done"},      32'(bus.done_out), 32'd0);
    checkOutput({tag, "_error"},     32'(bus.error_out), 32'd0);
    checkOutput({tag, "_addr"},      32'(bus.mem_load_addr_out), 32'd0);
    checkOutput({tag, "_m"},         32'(bus.mem_m_load_size_out), 32'd0);
    checkOutput({tag, "_n"},         32'(bus.mem_n_load_size_out), 32'd0);
    checkOutput({tag, "_elem"},      bus.mem_load_element_out, 32'd0);
  endtask

  // Stream srcData[start..start+count-1], optionally with random idle gaps.
  task automatic fillSource(input int start, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      checkOutput("fill_src_ready", 32'(bus.src_ready_out), 32'd1);
      checkOutput("fill_load_en",   32'(bus.load_en_out), 32'd0);
      bus.src_valid_in   = 1'b1;
      bus.src_element_in = srcData[start + i];
      @(negedge clk);
      bus.src_valid_in   = 1'b0;
    end
  endtask

  // Expect a full-rate burst, one gap cycle, then a single done pulse.
  task automatic checkBurst(input int start, input int count, input logic [2:0] addr,
                            input logic [2:0] m, input logic [2:0] n);
    bus.mem_load_ack_in = 1'b1;
    for (int k = 0; k < count; k++) begin
      checkOutput("burst_load_en", 32'(bus.load_en_out), 32'd1);
      checkOutput("burst_elem",    bus.mem_load_element_out, srcData[start + k]);
      checkOutput("burst_addr",    32'(bus.mem_load_addr_out), 32'(addr));
      checkOutput("burst_m",       32'(bus.mem_m_load_size_out), 32'(m));
      checkOutput("burst_n",       32'(bus.mem_n_load_size_out), 32'(n));
      @(negedge clk);
    end
    checkOutput("gap_load_en", 32'(bus.load_en_out), 32'd0);
    checkOutput("gap_busy",    32'(bus.busy_out), 32'd1);
    checkOutput("gap_done",    32'(bus.done_out), 32'd0);
    @(negedge clk);
    checkOutput("done_pulse",     32'(bus.done_out), 32'd1);
    checkOutput("done_busy",      32'(bus.busy_out), 32'd0);
    checkOutput("done_cmd_ready", 32'(bus.cmd_ready_out), 32'd1);
    @(negedge clk);
    checkOutput("done_cleared", 32'(bus.done_out), 32'd0);
  endtask

  // A rejected command: one error pulse, never leaves idle.
  task automatic expectReject(input string tag);
    checkOutput({tag, "_error"},     32'(bus.error_out), 32'd1);
    checkOutput({tag, "_busy"},      32'(bus.busy_out), 32'd0);
    checkOutput({tag, "_src_ready"}, 32'(bus.src_ready_out), 32'd0);
    checkOutput({tag, "_cmd_ready"}, 32'(bus.cmd_ready_out), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_error_clr"}, 32'(bus.error_out), 32'd0);
    checkOutput({tag, "_busy2"},     32'(bus.busy_out), 32'd0);
  endtask

  // Bound the whole run so a stuck design still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n                 = 1'b0;
    bus.cmd_valid_in      = 1'b0;
    bus.cmd_addr_in       = '0;
    bus.cmd_m_size_in     = '0;
    bus.cmd_n_size_in     = '0;
    bus.src_valid_in      = 1'b0;
    bus.src_element_in    = '0;
    bus.mem_load_ack_in   = 1'b1;
    bus.mem_load_error_in = 1'b0;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] 2x3 matrix with source gaps");
    applyStimulus(3'd1, 3'd2, 3'd3);
    checkOutput("accept_busy",      32'(bus.busy_out), 32'd1);
    checkOutput("accept_cmd_ready", 32'(bus.cmd_ready_out), 32'd0);
    fillSource(0, 6, 1'b1);
    checkBurst(0, 6, 3'd1, 3'd2, 3'd3);

    $display("[TB] rejected commands");
    applyStimulus(3'd0, 3'd0, 3'd2);
    expectReject("rej_m0");
    applyStimulus(3'd0, 3'(M + 1), 3'd2);
    expectReject("rej_mbig");

    $display("[TB] ack held low mid-drain");
    applyStimulus(3'd2, 3'd2, 3'd2);
    fillSource(0, 4, 1'b0);
    for (int k = 0; k < 7; k++) begin
      checkOutput("stall_load_en", 32'(bus.load_en_out), 32'd1);
      checkOutput("stall_elem",    bus.mem_load_element_out, srcData[idxSeq[k]]);
      bus.mem_load_ack_in = ackSeq[k];
      @(negedge clk);
    end
    bus.mem_load_ack_in = 1'b1;
    checkOutput("stall_gap_load_en", 32'(bus.load_en_out), 32'd0);
    @(negedge clk);
    checkOutput("stall_done", 32'(bus.done_out), 32'd1);
    @(negedge clk);

    $display("[TB] load error in second drain cycle");
    applyStimulus(3'd3, 3'd2, 3'd2);
    fillSource(4, 4, 1'b0);
    checkOutput("lerr_elem0", bus.mem_load_element_out, srcData[4]);
    @(negedge clk);
    checkOutput("lerr_load_en1", 32'(bus.load_en_out), 32'd1);
    checkOutput("lerr_elem1",    bus.mem_load_element_out, srcData[5]);
    bus.mem_load_error_in = 1'b1;
    @(negedge clk);
    bus.mem_load_error_in = 1'b0;
    checkOutput("lerr_error",     32'(bus.error_out), 32'd1);
    checkOutput("lerr_load_en",   32'(bus.load_en_out), 32'd0);
    checkOutput("lerr_busy",      32'(bus.busy_out), 32'd0);
    checkOutput("lerr_cmd_ready", 32'(bus.cmd_ready_out), 32'd1);
    @(negedge clk);
    checkOutput("lerr_error_clr", 32'(bus.error_out), 32'd0);

    $display("[TB] async reset mid-fill, then 1x1");
    applyStimulus(3'd1, 3'd2, 3'd3);
    fillSource(0, 2, 1'b0);
    checkOutput("prereset_busy", 32'(bus.busy_out), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkResetValues("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(3'd3, 3'd1, 3'd1);
    fillSource(6, 1, 1'b0);
    checkBurst(6, 1, 3'd3, 3'd1, 3'd1);

`ifdef MPU_FEED_TIMEOUT_EN
    $display("[TB] source stall timeout");
    applyStimulus(3'd0, 3'd2, 3'd2);
    fillSource(0, 2, 1'b0);
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      checkOutput("to_wait_error",   32'(bus.error_out), 32'd0);
      checkOutput("to_wait_load_en", 32'(bus.load_en_out), 32'd0);
    end
    @(negedge clk);
    checkOutput("to_error",   32'(bus.error_out), 32'd1);
    checkOutput("to_busy",    32'(bus.busy_out), 32'd0);
    checkOutput("to_load_en", 32'(bus.load_en_out), 32'd0);
    @(negedge clk);
    checkOutput("to_error_clr", 32'(bus.error_out), 32'd0);
    checkOutput("to_load_en2",  32'(bus.load_en_out), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
